// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage. Holds the program counter, drives the
//            instruction memory address/enable, and registers the fetched
//            word into the decode (ID) register set. It supports pipeline
//            stalls, exception flushes and single-cycle branch redirects.
//            A branch uses one delay slot. A branch that arrives during a
//            stall is parked as a pending redirect and taken on the next
//            fetch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1  sole clock, rising edge
//   rst_n         in   1  synchronous active-low reset
//   stall         in   1  hold request from decode/hazard logic
//   flush         in   1  exception redirect, discards fetched instruction
//   branch_en     in   1  single-cycle redirect request from decode
//   branch_target in  32  redirect address, valid while branch_en=1
//   inst_ce       out  1  instruction memory chip enable (registered)
//   inst_addr     out 32  instruction memory byte address (= PC register)
//   inst_data     in  32  instruction word, combinational from inst_addr
//   id_pc         out 32  PC of the instruction handed to decode
//   id_inst       out 32  instruction word handed to decode
//   id_valid      out  1  id_inst holds a real fetched instruction
//   id_adel       out  1  fetch address was not word-aligned
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        inst_ce,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    localparam logic [31:0] c_NOP      = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP  = 32'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend_v;
    logic [31:0] r_pend_tgt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_fetch;       // a real fetch happens at this edge
    logic        w_misaligned;  // current PC is not word-aligned
    logic [31:0] w_seq_pc;      // sequential successor, wraps modulo 2^32
    logic [31:0] w_next_pc;     // PC to load on a fetch cycle
    logic [31:0] w_fetch_word;  // word to place into the ID register

    assign w_fetch      = r_ce && !stall && !flush;
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_seq_pc     = r_pc + c_PC_STEP;

    // A parked redirect always wins over a fresh branch: the fresh branch
    // arrived after the stalled one and must be taken after it.
    assign w_next_pc    = r_pend_v  ? r_pend_tgt    :
                          branch_en ? branch_target :
                                      w_seq_pc;

    // A misaligned fetch never reaches decode as real data; the memory bus
    // content is meaningless for that address, so a NOP is substituted.
    assign w_fetch_word = w_misaligned ? c_NOP : inst_data;

    // Memory interface comes straight from registers.
    assign inst_ce   = r_ce;
    assign inst_addr = r_pc;

    // ------------------------------------------------------------------------
    // Sequential update
    // Priority: reset > (ce not yet up) > flush > stall > fetch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_ce       <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= 32'h0000_0000;
            id_pc      <= 32'h0000_0000;
            id_inst    <= c_NOP;
            id_valid   <= 1'b0;
            id_adel    <= 1'b0;
        end else if (!r_ce) begin
            // First edge out of reset only raises the chip enable; branch and
            // flush requests are meaningless before the first fetch.
            r_ce <= 1'b1;
        end else if (flush) begin
            // Exception redirect. id_pc is left alone so the exception logic
            // can still see the PC of the last instruction handed down.
            r_pc     <= EXC_VECTOR;
            r_pend_v <= 1'b0;
            id_valid <= 1'b0;
            id_inst  <= c_NOP;
            id_adel  <= 1'b0;
        end else if (stall) begin
            // PC and ID registers freeze; a branch seen now is parked. A later
            // branch during the same stall replaces the parked target.
            if (branch_en) begin
                r_pend_v   <= 1'b1;
                r_pend_tgt <= branch_target;
            end
        end else begin
            // Fetch cycle: hand the current word to decode (this is also the
            // delay slot when branch_en is high) and advance the PC.
            id_pc    <= r_pc;
            id_inst  <= w_fetch_word;
            id_valid <= 1'b1;
            id_adel  <= w_misaligned;
            r_pc     <= w_next_pc;

            if (r_pend_v) begin
                // Parked target consumed now; a coincident branch becomes
                // the next parked target instead of being lost.
                r_pend_v <= branch_en;
                if (branch_en) begin
                    r_pend_tgt <= branch_target;
                end
            end
        end
    end

    // w_fetch is the documented definition of a fetch cycle; it mirrors the
    // final else-branch above and is kept as a named signal for debug taps.
    logic w_fetch_unused;
    assign w_fetch_unused = w_fetch;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch. Directed scenarios for boot,
//            delay slot, stalled branch, flush, misaligned target, PC wrap and
//            reset during a pending redirect, followed by randomized traffic.
//            All outputs are compared every cycle against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_EXC_VEC  = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch #(
        .RESET_PC   (c_RESET_PC),
        .EXC_VECTOR (c_EXC_VEC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .inst_ce       (inst_ce),
        .inst_addr     (inst_addr),
        .inst_data     (inst_data),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .id_adel       (id_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: boot image at words 0 and 1, a scrambled pattern
    // elsewhere so every address returns a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0000_F025;
        else if (a == 32'h4) return 32'h241D_1000;
        else                 return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign inst_data = mem_word(inst_addr);

    // ------------------------------------------------------------------------
    // Reference model: the architectural view of the fetch stage.
    // ------------------------------------------------------------------------
    logic [31:0] m_pc, m_pend_tgt, m_id_pc, m_id_inst;
    logic        m_ce, m_pend_v, m_id_valid, m_id_adel;

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic b, input logic [31:0] t);
        if (!r) begin
            m_pc = c_RESET_PC; m_ce = 0; m_pend_v = 0; m_pend_tgt = 0;
            m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
        end else if (!m_ce) begin
            m_ce = 1;
        end else if (f) begin
            m_pc = c_EXC_VEC; m_pend_v = 0;
            m_id_valid = 0; m_id_inst = 0; m_id_adel = 0;
        end else if (s) begin
            if (b) begin m_pend_v = 1; m_pend_tgt = t; end
        end else begin
            // Instruction at the current PC goes to decode.
            m_id_pc    = m_pc;
            m_id_adel  = (m_pc % 4) != 0;
            m_id_inst  = m_id_adel ? 32'h0 : mem_word(m_pc);
            m_id_valid = 1;
            // Then the PC moves on: oldest redirect first.
            if (m_pend_v) begin
                m_pc = m_pend_tgt;
                m_pend_v = b;
                if (b) m_pend_tgt = t;
            end else if (b) begin
                m_pc = t;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("inst_ce",   {31'h0, inst_ce},  {31'h0, m_ce});
        check("inst_addr", inst_addr,         m_pc);
        check("id_pc",     id_pc,             m_id_pc);
        check("id_inst",   id_inst,           m_id_inst);
        check("id_valid",  {31'h0, id_valid}, {31'h0, m_id_valid});
        check("id_adel",   {31'h0, id_adel},  {31'h0, m_id_adel});
    endtask

    // Drive inputs, take one rising edge, update model, compare #1 later.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic b, input logic [31:0] t);
        rst_n = r; stall = s; flush = f; branch_en = b; branch_target = t;
        @(posedge clk);
        model_edge(r, s, f, b, t);
        #1;
        check_all();
    endtask

    logic [31:0] saved_addr;
    logic [31:0] saved_idpc;

    initial begin
        rst_n = 0; stall = 0; flush = 0; branch_en = 0; branch_target = 0;

        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h1234);
        check("rst_addr", inst_addr, c_RESET_PC);
        check("rst_ce", {31'h0, inst_ce}, 32'h0);

        // Boot sequence: E0, E1, E2
        step(1, 0, 0, 0, 0);
        check("boot_e0_ce", {31'h0, inst_ce}, 32'h1);
        step(1, 0, 0, 0, 0);
        check("boot_e1_inst", id_inst, 32'h0000_F025);
        check("boot_e1_addr", inst_addr, 32'h4);
        step(1, 0, 0, 0, 0);
        check("boot_e2_inst", id_inst, 32'h241D_1000);

        // Run sequentially up to 0x20, then branch with delay slot
        for (int i = 0; i < 16 && m_pc != 32'h20; i++) step(1, 0, 0, 0, 0);
        check("reach_0x20", inst_addr, 32'h20);
        step(1, 0, 0, 1, 32'h50);
        check("dslot_idpc", id_pc, 32'h20);
        check("br_addr", inst_addr, 32'h50);

        // Stall three cycles, branch in the second
        saved_addr = inst_addr;
        saved_idpc = id_pc;
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'h100);
        step(1, 1, 0, 0, 32'h999);
        check("stall_addr", inst_addr, saved_addr);
        check("stall_idpc", id_pc, saved_idpc);
        step(1, 0, 0, 0, 0);
        check("pend_taken", inst_addr, 32'h100);
        check("pend_idpc", id_pc, saved_addr);
        step(1, 0, 0, 0, 0);
        check("pend_clear", inst_addr, 32'h104);

        // Flush with stall and branch, with a redirect already parked
        step(1, 1, 0, 1, 32'h300);
        step(1, 1, 1, 1, 32'h200);
        check("flush_valid", {31'h0, id_valid}, 32'h0);
        check("flush_inst", id_inst, 32'h0);
        check("flush_addr", inst_addr, 32'h80);
        step(1, 0, 0, 0, 0);
        check("flush_nopend", inst_addr, 32'h84);

        // Misaligned target and PC wrap
        step(1, 0, 0, 1, 32'h42);
        step(1, 0, 0, 0, 0);
        check("adel_flag", {31'h0, id_adel}, 32'h1);
        check("adel_nop", id_inst, 32'h0);
        check("adel_pc", id_pc, 32'h42);
        step(1, 0, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0);
        check("wrap_addr", inst_addr, 32'h0);

        // Reset while a redirect is parked and stall is high
        step(1, 1, 0, 1, 32'h400);
        step(0, 1, 0, 0, 0);
        check("rst_mid_valid", {31'h0, id_valid}, 32'h0);
        check("rst_mid_addr", inst_addr, c_RESET_PC);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_resume", inst_addr, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, f, b;
            logic [31:0] t;
            r = ($urandom_range(0, 63) != 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 15) == 0);
            b = ($urandom_range(0, 3) == 0);
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step(r, s, f, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-002 Parameter: EXC_VECTOR, 32'h0000_0080, PC loaded on flush.
REQ-003 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port: stall, input, 1, hold request from the decode/hazard logic.
REQ-006 Port: flush, input, 1, exception redirect; discards the fetched instruction.
REQ-007 Port: branch_en, input, 1, single-cycle redirect request from the decode stage.
REQ-008 Port: branch_target, input, 32, redirect address, valid while branch_en=1.
REQ-009 Port: inst_ce, output, 1, instruction memory chip enable.
REQ-010 Port: inst_addr, output, 32, byte address to instruction memory; equals the PC register.
REQ-011 Port: inst_data, input, 32, instruction word from memory, combinational from inst_addr (same cycle).
REQ-012 Port: id_pc, output, 32, registered PC of the instruction handed to decode.
REQ-013 Port: id_inst, output, 32, registered instruction word.
REQ-014 Port: id_valid, output, 1, id_inst holds a real fetched instruction.
REQ-015 Port: id_adel, output, 1, fetch address was not word-aligned.

Function
REQ-016 State: pc (32), ce_r (1), pend_v (1), pend_tgt (32), ID register set (id_pc, id_inst, id_valid, id_adel).
REQ-017 inst_ce = ce_r; inst_addr = pc; both outputs are driven directly from registers.
REQ-018 "Fetch cycle": ce_r=1 and stall=0 and flush=0.
REQ-019 Edge priority: reset > flush > stall > pending/branch redirect > sequential.
REQ-020 First edge with rst_n=1: ce_r<=1; pc, pend_v and the ID registers are unchanged.
REQ-021 Fetch cycle: id_pc<=pc, id_inst<=inst_data, id_valid<=1, id_adel<=(pc[1:0]!=0).
REQ-022 Fetch cycle with pc[1:0]!=0: id_inst<=32'h0 (NOP); the data bus is ignored.
REQ-023 Next pc in a fetch cycle: pend_tgt if pend_v; else branch_target if branch_en; else pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-024 Pend usage: when pend_tgt is consumed, pend_v<=0; if branch_en is also high that cycle, the new target is held as pending.
REQ-025 No flush of the fetched instruction on branch: the instruction fetched in the branch_en cycle is the delay slot and enters ID normally.
REQ-026 Stall with ce_r=1: pc and all ID registers hold.
REQ-027 Stall with branch_en=1: pend_v<=1 and pend_tgt<=branch_target; a later branch_en overwrites the held target.
REQ-028 Flush (ce_r=1, any stall value): pc<=EXC_VECTOR, pend_v<=0, id_valid<=0, id_inst<=0, id_adel<=0; id_pc holds.
REQ-029 Flush always overrides stall and any branch request in the same cycle.
REQ-030 Redirect to a misaligned target is not rejected: pc loads it, and id_adel is flagged when that PC is fetched.
REQ-031 Branch_en or flush while ce_r=0 is ignored.

Reset
REQ-032 rst_n=0 at an edge, including mid-stall, mid-pending or mid-flush, sets: pc<=RESET_PC, ce_r<=0, pend_v<=0, pend_tgt<=0, id_pc<=0, id_inst<=0, id_valid<=0, id_adel<=0.
REQ-033 During reset, inst_ce=0 and inst_addr=RESET_PC from the first reset edge onward.

Verification
REQ-034 Boot image loaded (word0=0x0000F025, word1=0x241D1000), release reset -> edge E0: inst_ce=1. Edge E1: id_pc=0, id_inst=0x0000F025, id_valid=1, inst_addr=4. Edge E2: id_inst=0x241D1000.
REQ-035 branch_en=1, target=0x50, fetched at pc=0x20 -> the next ID entry is pc 0x20 (delay slot); the following inst_addr=0x50.
REQ-036 stall=1 for 3 cycles with branch_en pulsed in the 2nd -> pc and ID registers frozen; after stall drops, inst_addr jumps to the stored target and pend_v clears.
REQ-037 flush together with stall and branch_en -> id_valid=0, id_inst=0, inst_addr=0x80 next cycle, pending cleared.
REQ-038 branch_target=0x0000_0042 -> the fetch at 0x42 yields id_adel=1, id_inst=0; pc=0xFFFF_FFFC sequential -> next inst_addr=0.
REQ-039 rst_n=0 while pend_v=1 and stall=1 -> all registers at reset values next edge; after release, fetching resumes from RESET_PC with no stale redirect.
